// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op and state encodings for the iterative multiply/divide unit
package muldiv_pkg;
    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;
endpackage

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: start/busy/done handshake, direct HI/LO write port and HI/LO results
//   master drives start, op, a, b, cancel, we_hi, we_lo, wd
//   slave drives busy, done, dz, hi, lo
interface muldiv_seq_if #(parameter int wide = 32);
    logic            start;
    logic [1:0]      op;
    logic [wide-1:0] a;
    logic [wide-1:0] b;
    logic            cancel;
    logic            we_hi;
    logic            we_lo;
    logic [wide-1:0] wd;
    logic            busy;
    logic            done;
    logic            dz;
    logic [wide-1:0] hi;
    logic [wide-1:0] lo;
    modport master (output start, op, a, b, cancel, we_hi, we_lo, wd, input busy, done, dz, hi, lo);
    modport slave (input start, op, a, b, cancel, we_hi, we_lo, wd, output busy, done, dz, hi, lo);
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational multiply (shift-add) or restoring-divide iteration
//   mode: 0 multiply, 1 divide; acc: 2*wide accumulator; operand: multiplicand or divisor
//   acc_nxt: accumulator after the step; q_bit: quotient bit (0 when multiplying)
module muldiv_step #(parameter int wide = 32) (
    input  logic              mode,
    input  logic [2*wide-1:0] acc,
    input  logic [wide-1:0]   operand,
    output logic [2*wide-1:0] acc_nxt,
    output logic              q_bit
);
    logic [wide:0] sum;
    logic [wide:0] trial;
    always_comb begin
        sum     = {1'b0, acc[2*wide-1:wide]} + (acc[0] ? {1'b0, operand} : '0);
        trial   = acc[2*wide-1:wide-1] - {1'b0, operand};
        q_bit   = mode & ~trial[wide];
        // divide leaves bit 0 clear; the caller ORs q_bit in
        acc_nxt = mode ? {(q_bit ? trial[wide-1:0] : acc[2*wide-2:wide-1]), acc[wide-2:0], 1'b0}
                       : {sum, acc[wide-1:1]};
    end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative signed/unsigned multiply/divide unit owning the HI/LO pair
//   clk, rst: clock and asynchronous active-high reset
//   bus: start/op/a/b/cancel request, we_hi/we_lo/wd direct writes, busy/done/dz/hi/lo status
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter  int wide = 32,
    localparam int cw   = $clog2(wide) + 1
) (
    input logic          clk,
    input logic          rst,
    muldiv_seq_if.slave  bus
);
    state_t            state_q, state_d;
    logic [cw-1:0]     cnt_q, cnt_d;
    logic              div_q, div_d;
    logic              sa_q, sa_d, sb_q, sb_d, bz_q, bz_d, dz_q, dz_d;
    logic [wide-1:0]   opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d;
    logic [2*wide-1:0] acc_q, acc_d, acc_step, prod;
    logic [wide-1:0]   am, bm, quo, rem;
    logic              sa_in, sb_in, q_bit;

    muldiv_step #(.wide(wide)) u_step (
        .mode    (div_q),
        .acc     (acc_q),
        .operand (opnd_q),
        .acc_nxt (acc_step),
        .q_bit   (q_bit)
    );

    always_comb begin
        sa_in   = bus.op[0] & bus.a[wide-1];
        sb_in   = bus.op[0] & bus.b[wide-1];
        am      = sa_in ? -bus.a : bus.a;
        bm      = sb_in ? -bus.b : bus.b;
        prod    = (sa_q ^ sb_q) ? -acc_q : acc_q;
        quo     = (sa_q ^ sb_q) ? -acc_q[wide-1:0] : acc_q[wide-1:0];
        rem     = sa_q ? -acc_q[2*wide-1:wide] : acc_q[2*wide-1:wide];
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        bz_d    = bz_q;
        dz_d    = dz_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                hi_d = bus.we_hi ? bus.wd : hi_q;
                lo_d = bus.we_lo ? bus.wd : lo_q;
                if (bus.start && !bus.cancel) begin
                    state_d = S_CALC;
                    cnt_d   = '0;
                    div_d   = bus.op[1];
                    sa_d    = sa_in;
                    sb_d    = sb_in;
                    bz_d    = bus.b == '0;
                    opnd_d  = bus.op[1] ? bm : am;
                    acc_d   = {{wide{1'b0}}, bus.op[1] ? am : bm};
                end
            end
            S_CALC: begin
                state_d = bus.cancel ? S_IDLE : (cnt_q == cw'(wide - 1) ? S_FIX : S_CALC);
                cnt_d   = cnt_q + cw'(1);
                acc_d   = acc_step | {{(2*wide-1){1'b0}}, q_bit};
            end
            S_FIX: begin
                state_d = bus.cancel ? S_IDLE : S_DONE;
                if (!bus.cancel) begin
                    {hi_d, lo_d} = div_q ? {rem, quo} : prod;
                    // dz is sticky across multiplies by zero; any other completion rewrites it
                    dz_d = (div_q && bz_q) ? 1'b1 : (bz_q ? dz_q : 1'b0);
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            bz_q    <= 1'b0;
            dz_q    <= 1'b0;
            opnd_q  <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            bz_q    <= bz_d;
            dz_q    <= dz_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy = (state_q == S_CALC) || (state_q == S_FIX);
    assign bus.done = state_q == S_DONE;
    assign bus.dz   = dz_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed scoreboard bench for muldiv_seq
module tb_muldiv_seq;
    import muldiv_pkg::*;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    muldiv_seq_if #(.wide(W)) bus ();
    muldiv_seq #(.wide(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int           tests = 0;
    int           fails = 0;
    res_t         sb_q[$];
    logic [W-1:0] hi_m = '0;
    logic [W-1:0] lo_m = '0;
    logic         dz_m = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic dz_prev);
        longint sa, sb, p;
        res_t   r;
        if (op[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end
        if (!op[1]) begin
            p    = sa * sb;
            r.hi = p[63:32];
            r.lo = p[31:0];
            r.dz = (b == 0) ? dz_prev : 1'b0;
        end else if (b == 0) begin
            r.lo = (op[0] && a[W-1]) ? 32'd1 : 32'hFFFF_FFFF;
            r.hi = a;
            r.dz = 1'b1;
        end else begin
            p    = sa / sb;
            r.lo = p[31:0];
            p    = sa % sb;
            r.hi = p[31:0];
            r.dz = 1'b0;
        end
        return r;
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit noise);
        int   edges, busy_cnt;
        res_t e;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        sb_q.push_back(model(op, a, b, dz_m));
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (noise) begin bus.a = $urandom; bus.b = $urandom; end
        edges = 0;
        busy_cnt = 0;
        while (!bus.done && edges < 100) begin
            busy_cnt += int'(bus.busy);
            if (noise && edges == 5) begin
                bus.start = 1'b1; bus.op = 2'($urandom); bus.we_hi = 1'b1; bus.we_lo = 1'b1; bus.wd = $urandom;
            end
            if (noise && edges == 6) begin
                bus.start = 1'b0; bus.we_hi = 1'b0; bus.we_lo = 1'b0;
            end
            @(posedge clk); #1;
            edges++;
        end
        check("latency", edges, W + 1);
        check("busy_cycles", busy_cnt, W + 1);
        e = sb_q.pop_front();
        check("hi", bus.hi, e.hi);
        check("lo", bus.lo, e.lo);
        check("dz", bus.dz, e.dz);
        hi_m = e.hi; lo_m = e.lo; dz_m = e.dz;
        @(posedge clk); #1;
        check("done_one_cycle", bus.done, 0);
        check("idle_not_busy", bus.busy, 0);
    endtask

    initial begin
        int done_cnt;
        bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
        bus.cancel = 1'b0; bus.we_hi = 1'b0; bus.we_lo = 1'b0; bus.wd = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        check("rst_dz", bus.dz, 0);
        rst = 1'b0;

        @(negedge clk);
        bus.we_hi = 1'b1; bus.we_lo = 1'b1; bus.wd = 32'hA5A5_0F0F;
        @(posedge clk); #1;
        bus.we_hi = 1'b0; bus.we_lo = 1'b0;
        check("wr_both_hi", bus.hi, 32'hA5A5_0F0F);
        check("wr_both_lo", bus.lo, 32'hA5A5_0F0F);
        hi_m = 32'hA5A5_0F0F; lo_m = 32'hA5A5_0F0F;

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        run_op(OP_MULT,  32'hFFFF_FFF9, 32'd6, 1'b0);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(OP_DIVU,  32'd100, 32'd0, 1'b0);
        run_op(OP_DIVU,  32'd100, 32'd7, 1'b0);
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op(OP_DIV,   32'hFFFF_FF9C, 32'd0, 1'b0);

        @(negedge clk);
        bus.we_hi = 1'b1; bus.wd = 32'h1234;
        @(posedge clk); #1;
        bus.we_hi = 1'b0;
        check("wr_hi", bus.hi, 32'h1234);
        check("wr_hi_lo_kept", bus.lo, lo_m);
        hi_m = 32'h1234;
        @(negedge clk);
        bus.we_lo = 1'b1; bus.wd = 32'h5678;
        @(posedge clk); #1;
        bus.we_lo = 1'b0;
        check("wr_lo", bus.lo, 32'h5678);
        lo_m = 32'h5678;
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'd3; bus.b = 32'd5;
        @(posedge clk); #1;
        for (int i = 1; i <= 9; i++) begin
            bus.start = i[0];
            bus.a = $urandom;
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        check("busy_before_cancel", bus.busy, 1);
        bus.cancel = 1'b1;
        @(posedge clk); #1;
        bus.cancel = 1'b0;
        check("cancel_busy", bus.busy, 0);
        check("cancel_done", bus.done, 0);
        check("cancel_hi", bus.hi, hi_m);
        check("cancel_lo", bus.lo, lo_m);
        check("cancel_dz", bus.dz, dz_m);
        done_cnt = 0;
        repeat (40) begin
            @(posedge clk); #1;
            done_cnt += int'(bus.done);
        end
        check("cancel_no_done", done_cnt, 0);
        check("cancel_hi_later", bus.hi, hi_m);

        for (int i = 0; i < 6; i++)
            run_op(2'($urandom), $urandom, (i == 2) ? 32'd0 : $urandom, i[0]);

        run_op(OP_DIVU, 32'd5, 32'd0, 1'b0);
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'd3; bus.b = 32'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        bus.we_hi = 1'b1; bus.wd = 32'hDEAD;
        @(posedge clk); #1;
        bus.we_hi = 1'b0;
        check("we_hi_in_calc", bus.hi, hi_m);
        check("busy_mid_calc", bus.busy, 1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_done", bus.done, 0);
        check("arst_hi", bus.hi, 0);
        check("arst_lo", bus.lo, 0);
        check("arst_dz", bus.dz, 0);
        hi_m = '0; lo_m = '0; dz_m = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_op(OP_MULTU, 32'd3, 32'd5, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
